// File: rtl/des_keyspace_scheduler.sv
// des_keyspace_scheduler: hands DES key chunks to cracker cores round-robin and records match status.
// Optional FOUND_STOP_EN: the first match seen while dispatching ends the search early.
module des_keyspace_scheduler #(
    parameter int NB_CORES = 4,
    parameter int KEY_W    = 56,
    parameter int CHUNK_W  = 20,
    parameter int HIT_W    = 16,
    localparam int IDX_W   = KEY_W - CHUNK_W
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cfg_start,
    input  logic                      cfg_abort,
    input  logic [IDX_W-1:0]          cfg_first_chunk,
    input  logic [IDX_W-1:0]          cfg_last_chunk,
    input  logic [NB_CORES-1:0]       core_req,
    input  logic [NB_CORES-1:0]       core_busy,
    input  logic [NB_CORES-1:0]       core_found,
    input  logic [NB_CORES*KEY_W-1:0] core_found_key,
    output logic [NB_CORES-1:0]       core_grant,
    output logic [IDX_W-1:0]          core_chunk,
    output logic                      core_flush,
    output logic                      sts_busy,
    output logic                      sts_done,
    output logic                      sts_found,
    output logic [KEY_W-1:0]          sts_found_key,
    output logic [IDX_W-1:0]          sts_next_chunk,
    output logic [HIT_W-1:0]          sts_hit_count
);
    localparam int PTR_W = NB_CORES > 1 ? $clog2(NB_CORES) : 1;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   last_chunk;
    logic [NB_CORES-1:0] req_avail;
    logic               gnt_vld;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   idx;
    logic [KEY_W-1:0]   found_key;
    logic [HIT_W:0]     found_cnt;
    logic [HIT_W:0]     hit_sum;
    logic               active;

    assign active    = state == DISPATCH || state == DRAIN;
    // the core granted last cycle still shows its request, so it sits out one round
    assign req_avail = core_req & ~core_grant;
    assign hit_sum   = {1'b0, sts_hit_count} + found_cnt;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NB_CORES; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NB_CORES);
            if (!gnt_vld && req_avail[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        found_key = '0;
        found_cnt = '0;
        for (int i = NB_CORES - 1; i >= 0; i--) begin
            found_cnt = found_cnt + (HIT_W+1)'(core_found[i]);
            if (core_found[i])
                found_key = core_found_key[i*KEY_W +: KEY_W];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            last_chunk     <= '0;
            core_grant     <= '0;
            core_chunk     <= '0;
            core_flush     <= 1'b0;
            sts_busy       <= 1'b0;
            sts_done       <= 1'b0;
            sts_found      <= 1'b0;
            sts_found_key  <= '0;
            sts_next_chunk <= '0;
            sts_hit_count  <= '0;
        end else begin
            core_grant <= '0;
            core_flush <= 1'b0;
            if (active && |core_found) begin
                if (!sts_found)
                    sts_found_key <= found_key;
                sts_found     <= 1'b1;
                sts_hit_count <= hit_sum[HIT_W] ? '1 : hit_sum[HIT_W-1:0];
            end
            if (cfg_abort && active) begin
                state      <= IDLE;
                sts_busy   <= 1'b0;
                sts_done   <= 1'b0;
                core_flush <= 1'b1;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (cfg_start) begin
                            sts_found      <= 1'b0;
                            sts_found_key  <= '0;
                            sts_hit_count  <= '0;
                            sts_next_chunk <= cfg_first_chunk;
                            last_chunk     <= cfg_last_chunk;
                            state          <= cfg_first_chunk <= cfg_last_chunk ? DISPATCH : DONE;
                            sts_busy       <= cfg_first_chunk <= cfg_last_chunk;
                            sts_done       <= cfg_first_chunk > cfg_last_chunk;
                        end
                    end
                    DISPATCH: begin
`ifdef FOUND_STOP_EN
                        if (|core_found) begin
                            state      <= DRAIN;
                            core_flush <= 1'b1;
                        end else
`endif
                        if (gnt_vld) begin
                            core_grant     <= NB_CORES'(1) << gnt_idx;
                            core_chunk     <= sts_next_chunk;
                            sts_next_chunk <= sts_next_chunk + IDX_W'(1);
                            rr_ptr         <= gnt_idx == PTR_W'(NB_CORES - 1) ? '0 : gnt_idx + PTR_W'(1);
                            // equality, not magnitude: last may be all-ones and next then wraps
                            if (sts_next_chunk == last_chunk)
                                state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!(|core_busy) && !(|core_grant)) begin
                            state    <= DONE;
                            sts_busy <= 1'b0;
                            sts_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
